// File: rtl/downsample_pkg.sv
// Shared defaults, FSM encoding and read-tag type
// for the 2x2 box-average image downsampler.
package downsample_pkg;

    localparam int DEF_IMG_W  = 256;
    localparam int DEF_IMG_H  = 256;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SRC_AW = 16;
    localparam int DEF_DST_AW = 14;
    localparam int DEF_RD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } ds_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] p;
    } rd_tag_t;

endpackage

// File: rtl/image_downsampler_2x2_box_accumulator.sv
// Sums the four pixels of one 2x2 block as they return from the DRAM
// and emits the rounded average on the fourth.
module box_accumulator
    import downsample_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              tag_valid,
    input  logic [1:0]        tag_p,
    input  logic [DATA_W-1:0] pix,
    output logic [DATA_W-1:0] avg,
    output logic              avg_valid
);

    localparam int ACC_W = DATA_W + 2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] rnd;

    // Four DATA_W pixels plus the rounding constant never exceed ACC_W bits.
    assign sum = acc + ACC_W'(pix);
    assign rnd = sum + ACC_W'(2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (tag_valid) begin
                unique case (tag_p)
                    2'd0: acc <= ACC_W'(pix);
                    2'd1,
                    2'd2: acc <= sum;
                    default: begin
                        avg       <= rnd[ACC_W-1:2];
                        avg_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/image_downsampler_2x2.sv
// Frame sequencer for the 2x2 downsampler: walks the source image in
// block order, tracks read latency with a tag line, writes raster results.
module image_downsampler_2x2
    import downsample_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SRC_AW = DEF_SRC_AW,
    parameter int DST_AW = DEF_DST_AW,
    parameter int RD_LAT = DEF_RD_LAT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [DST_AW-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_wen,
    output logic              busy,
    output logic              done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    // Dimensions are powers of two, so the last block index is all ones.
    localparam logic [XW-2:0] OX_LAST = '1;
    localparam logic [YW-2:0] OY_LAST = '1;

    ds_state_t state, state_n;

    logic [XW-2:0]     ox;
    logic [YW-2:0]     oy;
    logic [1:0]        p;
    logic [DST_AW-1:0] wr_cnt;

    rd_tag_t iss_tag;
    rd_tag_t tag_sr [RD_LAT];
    rd_tag_t out_tag;

    logic issue;
    logic last_rd;
    logic pipe_empty;
    logic fire;

    assign issue   = (state == ISSUE);
    assign last_rd = issue && (p == 2'd3) && (ox == OX_LAST) && (oy == OY_LAST);
    assign out_tag = tag_sr[RD_LAT-1];
    assign fire    = out_tag.valid && (out_tag.p == 2'd3);
    assign busy    = issue || (state == DRAIN);
    assign done    = (state == FINISH);

    always_comb begin
        pipe_empty = !iss_tag.valid;
        for (int i = 0; i < RD_LAT; i++) begin
            if (tag_sr[i].valid) pipe_empty = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = ISSUE;
            ISSUE:   if (last_rd) state_n = DRAIN;
            DRAIN:   if (pipe_empty) state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address {2*oy+p[1], 2*ox+p[0]} is a plain bit interleave of the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ox       <= '0;
            oy       <= '0;
            p        <= '0;
            src_addr <= '0;
            iss_tag  <= '0;
        end else begin
            iss_tag <= '{valid: issue, p: p};
            if ((state == IDLE) && start) begin
                ox <= '0;
                oy <= '0;
                p  <= '0;
            end else if (issue) begin
                src_addr <= SRC_AW'({oy, p[1], ox, p[0]});
                p        <= p + 2'd1;
                if (p == 2'd3) begin
                    ox <= ox + 1'b1;
                    if (ox == OX_LAST) oy <= oy + 1'b1;
                end
            end
        end
    end

    // The tag emerges exactly when src_data for its address is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_sr[i] <= '0;
        end else begin
            tag_sr[0] <= iss_tag;
            for (int i = 1; i < RD_LAT; i++) tag_sr[i] <= tag_sr[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt   <= '0;
            dst_addr <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                wr_cnt <= '0;
            end else if (fire) begin
                dst_addr <= wr_cnt;
                wr_cnt   <= wr_cnt + 1'b1;
            end
        end
    end

    box_accumulator #(
        .DATA_W(DATA_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .tag_valid(out_tag.valid),
        .tag_p    (out_tag.p),
        .pix      (src_data),
        .avg      (dst_data),
        .avg_valid(dst_wen)
    );

endmodule

// File: tb/tb_image_downsampler_2x2.sv
// Directed/random bench for image_downsampler_2x2 on a reduced 32x8 frame
// with a 2-cycle DRAM model and an arithmetic box-average reference.
module tb_image_downsampler_2x2;

    localparam int W    = 32;
    localparam int H    = 8;
    localparam int DW   = 8;
    localparam int SAW  = 8;
    localparam int DAW  = 6;
    localparam int LAT  = 2;
    localparam int NPIX = W * H;
    localparam int NOUT = NPIX / 4;
    localparam int NRD  = NPIX;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [SAW-1:0] src_addr;
    logic [DW-1:0]  src_data;
    logic [DAW-1:0] dst_addr;
    logic [DW-1:0]  dst_data;
    logic           dst_wen;
    logic           busy;
    logic           done;

    image_downsampler_2x2 #(
        .IMG_W(W), .IMG_H(H), .DATA_W(DW),
        .SRC_AW(SAW), .DST_AW(DAW), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .src_data(src_data),
        .dst_addr(dst_addr), .dst_data(dst_data),
        .dst_wen(dst_wen), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Image memory with a two-stage registered read path
    logic [DW-1:0]  img [NPIX];
    logic [SAW-1:0] a1, a2;
    always @(posedge clk) begin
        a1 <= src_addr;
        a2 <= a1;
    end
    assign src_data = img[a2];

    int cyc = 0;
    int t0 = 0;
    int tests = 0;
    int fails = 0;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [31:0] wr_rel  [$];
    int   done_cnt;
    int   done_rel;
    logic busy_at_done;
    int   sa_log [NRD];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (dst_wen) begin
            wr_addr.push_back(32'(dst_addr));
            wr_data.push_back(32'(dst_data));
            wr_rel.push_back(32'(rel));
        end
        if (done) begin
            done_cnt++;
            done_rel = rel;
            busy_at_done = busy;
        end
        if (rel >= 1 && rel <= NRD) sa_log[rel-1] = int'(src_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_src_addr"}, 32'(src_addr), 0);
        chk({tag, "_dst_addr"}, 32'(dst_addr), 0);
        chk({tag, "_dst_data"}, 32'(dst_data), 0);
        chk({tag, "_dst_wen"}, 32'(dst_wen), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic run_frame(input int x1, input int x2, input int abort_at, input bit fin_start);
        int rel;
        int wr_at_abort;
        bit fin;
        wr_addr.delete();
        wr_data.delete();
        wr_rel.delete();
        done_cnt = 0;
        done_rel = -1;
        busy_at_done = 1'b1;
        fin = 1'b0;
        @(negedge clk);
        #1;
        start = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < NRD + 40; k++) begin
            @(negedge clk);
            #1;
            rel = cyc - t0;
            start = (rel + 1 == x1) || (rel + 1 == x2);
            if (fin) begin
                chk("finish_start_ignored_busy", 32'(busy), 0);
                fin = 1'b0;
            end
            if (fin_start && done) begin
                start = 1'b1;
                fin = 1'b1;
            end
            if (rel == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check_zero_outputs("abort");
                wr_at_abort = wr_addr.size();
                chk("abort_writes_before", 32'(wr_at_abort), 32'((abort_at - 7) / 4 + 1));
                start = 1'b0;
                repeat (3) @(negedge clk);
                #1 rst = 1'b0;
                repeat (NOUT) @(negedge clk);
                #1;
                chk("abort_no_more_writes", 32'(wr_addr.size()), 32'(wr_at_abort));
                chk("abort_no_done", 32'(done_cnt), 0);
                chk("abort_idle_busy", 32'(busy), 0);
                return;
            end
        end
        start = 1'b0;
    endtask

    task automatic verify_frame(input string name);
        int n;
        int ox, oy, b, pp, e, base;
        chk({name, "_wr_count"}, 32'(wr_addr.size()), NOUT);
        chk({name, "_done_count"}, 32'(done_cnt), 1);
        chk({name, "_done_cycle"}, 32'(done_rel), 32'(NRD + 4));
        chk({name, "_busy_at_done"}, 32'(busy_at_done), 0);
        chk({name, "_src_hold"}, 32'(src_addr), 32'(NPIX - 1));
        n = (wr_addr.size() < NOUT) ? wr_addr.size() : NOUT;
        for (int i = 0; i < n; i++) begin
            ox = i % (W / 2);
            oy = i / (W / 2);
            base = 2 * oy * W + 2 * ox;
            e = (int'(img[base]) + int'(img[base + 1]) +
                 int'(img[base + W]) + int'(img[base + W + 1]) + 2) / 4;
            chk({name, "_data"}, wr_data[i], 32'(e));
            chk({name, "_addr"}, wr_addr[i], 32'(i));
            chk({name, "_wen_cycle"}, wr_rel[i], 32'(5 + LAT + 4 * i));
        end
        for (int j = 0; j < NRD; j++) begin
            pp = j % 4;
            b  = j / 4;
            ox = b % (W / 2);
            oy = b / (W / 2);
            chk({name, "_src_seq"}, 32'(sa_log[j]),
                32'((2 * oy + pp / 2) * W + 2 * ox + pp % 2));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) img[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Column ramp: each block averages x and x+1, rounding up to 2*ox+1
        for (int i = 0; i < NPIX; i++) img[i] = 8'((i % W) & 8'hFF);
        run_frame(-1, -1, -1, 1'b0);
        verify_frame("ramp");
        chk("ramp_addr0", wr_data[0], 1);
        chk("ramp_addr15", wr_data[15], 31);

        for (int i = 0; i < NPIX; i++) img[i] = 8'hFF;
        run_frame(-1, -1, -1, 1'b0);
        verify_frame("const255");
        chk("const255_last", wr_data[NOUT-1], 255);

        for (int i = 0; i < NPIX; i++) img[i] = 8'h00;
        run_frame(-1, -1, -1, 1'b0);
        verify_frame("const0");

        // Rounding blocks at dst_addr 0..4, rest random
        fill_random();
        begin
            logic [7:0] blk [5][4];
            blk = '{'{0, 0, 0, 1}, '{0, 0, 1, 1}, '{0, 1, 1, 1},
                    '{1, 1, 1, 1}, '{3, 3, 3, 2}};
            for (int k = 0; k < 5; k++) begin
                img[2 * k]         = blk[k][0];
                img[2 * k + 1]     = blk[k][1];
                img[W + 2 * k]     = blk[k][2];
                img[W + 2 * k + 1] = blk[k][3];
            end
        end
        run_frame(-1, -1, -1, 1'b0);
        verify_frame("round");
        chk("round_0001", wr_data[0], 0);
        chk("round_0011", wr_data[1], 1);
        chk("round_0111", wr_data[2], 1);
        chk("round_1111", wr_data[3], 1);
        chk("round_3332", wr_data[4], 3);

        // Spurious starts while busy and during FINISH
        fill_random();
        run_frame(100, 200, -1, 1'b1);
        verify_frame("extra_start");

        // Abort mid-frame, then a clean frame
        fill_random();
        run_frame(-1, -1, 100, 1'b0);
        fill_random();
        run_frame(-1, -1, -1, 1'b0);
        verify_frame("after_abort");

        fill_random();
        run_frame(-1, -1, -1, 1'b0);
        verify_frame("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
